dmem_arbiter: RTL

Data-memory access controller between the pipeline MEM stage, a debug/loader port and the single-ported data memory. Gives the CPU fixed priority and serves the debug port in free cycles. Sequences multi-cycle accesses of a configurable wait-state count and stalls the pipeline until a CPU access completes. Sits between the MEM-stage control signals (MemRead/MemWrite, address, store data) and the data memory. Read data returns to the MEM/WB register unchanged.

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage has fixed priority, debug/loader port uses free cycles.
// Build option: define DMEM_FAIR_EN to add a starvation guard for the debug port.
module dmem_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int WAIT   = 0,
   parameter int STARVE = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_rd_i,
   input  logic              cpu_wr_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_stall_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   output logic              dbg_gnt_o,
   output logic              dbg_done_o,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, CPU, DBG} state_t;

   localparam logic [2:0] WAIT_C = 3'(WAIT);

   state_t      state_q, state_d;
   logic [2:0]  wcnt_q, wcnt_d;
   logic        cpu_req;
   logic        own_cpu, own_dbg;
   logic        last;
   logic        dbg_first;
   logic        act_cpu, act_dbg;

   assign cpu_req = cpu_rd_i | cpu_wr_i;

`ifdef DMEM_FAIR_EN
   localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

   logic [SW-1:0] starve_q;

   // Counts CPU completions that overtook a waiting debug request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve_q <= '0;
      else if (!dbg_req_i || own_dbg)
         starve_q <= '0;
      else if (own_cpu && last && starve_q != SW'(STARVE))
         starve_q <= starve_q + 1'b1;
   end

   assign dbg_first = dbg_req_i && (starve_q == SW'(STARVE));
`else
   logic cfg_unused;
   assign cfg_unused = (STARVE != 0);
   assign dbg_first  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Owner: combinational arbitration in IDLE, registered state otherwise.
   // A registered owner that drops its request loses the memory at once.
   always_comb begin
      own_cpu = 1'b0;
      own_dbg = 1'b0;
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         IDLE: begin
            if (cpu_req && !dbg_first)
               own_cpu = 1'b1;
            else if (dbg_req_i)
               own_dbg = 1'b1;
         end
         CPU:     own_cpu = cpu_req;
         DBG:     own_dbg = dbg_req_i;
         default: ;
      endcase
      last = (own_cpu || own_dbg) && (wcnt_q == WAIT_C);
      if (!(own_cpu || own_dbg) || last) begin
         state_d = IDLE;
         wcnt_d  = 3'd0;
      end else begin
         state_d = own_cpu ? CPU : DBG;
         wcnt_d  = wcnt_q + 3'd1;
      end
   end

   // Every output is forced low while reset is asserted.
   assign act_cpu = !rst && own_cpu;
   assign act_dbg = !rst && own_dbg;

   assign mem_rd_o    = (act_cpu && cpu_rd_i && !cpu_wr_i) || (act_dbg && !dbg_we_i);
   assign mem_wr_o    = (act_cpu && cpu_wr_i) || (act_dbg && dbg_we_i);
   assign mem_addr_o  = act_cpu ? cpu_addr_i  : (act_dbg ? dbg_addr_i  : '0);
   assign mem_wdata_o = act_cpu ? cpu_wdata_i : (act_dbg ? dbg_wdata_i : '0);
   assign cpu_rdata_o = act_cpu ? mem_rdata_i : '0;
   assign cpu_stall_o = !rst && cpu_req && !(own_cpu && last);
   assign dbg_gnt_o   = act_dbg;
   assign dbg_done_o  = act_dbg && last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         dbg_rdata_o <= '0;
      else if (own_dbg && last && !dbg_we_i)
         dbg_rdata_o <= mem_rdata_i;
   end

endmodule
